// File: rtl/enc_pkg.sv
// Shared definitions for the queued priority encoder: selection-mode constants,
// index-width derivation and a popcount helper.
package enc_pkg;

    localparam int ENC_FIXED = 0;
    localparam int ENC_RR    = 1;

    // Index width for n lines; never below one bit so N=2 still gets a real index.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic [6:0] popcount64(input logic [63:0] v);
        logic [6:0] c;
        c = '0;
        for (int i = 0; i < 64; i++) begin
            c = c + 7'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/prio_pick.sv
// Combinational picker: first set bit of vec searching downward from start,
// wrapping from 0 back to N-1.
module prio_pick #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic [N-1:0] vec,
    input  logic [W-1:0] start,
    output logic         found,
    output logic [W-1:0] idx
);

    // pos[gi] is the line visited gi steps into the downward search
    logic [W-1:0] pos [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_pos
        assign pos[gi] = (int'(start) >= gi) ? W'(int'(start) - gi)
                                             : W'(int'(start) + N - gi);
    end

    always_comb begin
        found = 1'b0;
        idx   = '0;
        // walk back-to-front so the earliest position in search order wins
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[pos[i]]) begin
                found = 1'b1;
                idx   = pos[i];
            end
        end
    end

endmodule

// File: rtl/prio_encoder_q.sv
// Registered priority encoder with sticky pending requests, serialised one grant
// per valid/ready handshake; fixed-priority or round-robin selection.
module prio_encoder_q
    import enc_pkg::*;
#(
    parameter int N       = 8,
    parameter int RR_MODE = ENC_FIXED,
    localparam int W      = idx_width(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req_i,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_idx,
    output logic [N-1:0] out_onehot,
    output logic [W:0]   pend_cnt
);

    localparam int CW = W + 1;

    logic [N-1:0] pending_reg, pending_next;
    logic [N-1:0] clr;
    logic         out_valid_reg;
    logic [W-1:0] out_idx_reg;
    logic [N-1:0] out_onehot_reg;
    logic [W:0]   pend_cnt_reg;
    logic [W-1:0] rr_ptr_reg;

    logic         load;
    logic         found;
    logic [W-1:0] sel_idx;
    logic [W-1:0] start;

    // Fixed priority is just a search that always starts at the top line.
    assign start = (RR_MODE == ENC_RR) ? rr_ptr_reg : W'(N - 1);

    prio_pick #(
        .N (N),
        .W (W)
    ) u_pick (
        .vec   (pending_reg),
        .start (start),
        .found (found),
        .idx   (sel_idx)
    );

    assign load = !out_valid_reg || out_ready;

    always_comb begin
        clr = '0;
        if (load && found) begin
            clr[sel_idx] = 1'b1;
        end
        // new requests are OR-ed after the clear so a colliding pulse survives
        pending_next = (pending_reg & ~clr) | req_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_reg    <= '0;
            out_valid_reg  <= 1'b0;
            out_idx_reg    <= '0;
            out_onehot_reg <= '0;
            pend_cnt_reg   <= '0;
            rr_ptr_reg     <= W'(N - 1);
        end else begin
            pending_reg  <= pending_next;
            pend_cnt_reg <= CW'(popcount64(64'(pending_next)));
            if (load) begin
                if (found) begin
                    out_valid_reg  <= 1'b1;
                    out_idx_reg    <= sel_idx;
                    out_onehot_reg <= N'(1) << sel_idx;
                    rr_ptr_reg     <= (sel_idx == '0) ? W'(N - 1) : sel_idx - 1'b1;
                end else begin
                    out_valid_reg  <= 1'b0;
                    out_onehot_reg <= '0;
                end
            end
        end
    end

    assign out_valid  = out_valid_reg;
    assign out_idx    = out_idx_reg;
    assign out_onehot = out_onehot_reg;
    assign pend_cnt   = pend_cnt_reg;

endmodule

// File: tb/tb_prio_encoder_q.sv
// Directed bench for prio_encoder_q: one fixed-priority and one round-robin
// instance, each with its own request/ready stimulus and a shared reset.
module tb_prio_encoder_q;

    localparam int N = 8;
    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req_fx = '0;
    logic [N-1:0] req_rr = '0;
    logic         rdy_fx = 1'b0;
    logic         rdy_rr = 1'b0;
    logic         vld_fx, vld_rr;
    logic [W-1:0] idx_fx, idx_rr;
    logic [N-1:0] oh_fx, oh_rr;
    logic [W:0]   cnt_fx, cnt_rr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    prio_encoder_q #(.N(N), .RR_MODE(0)) dut_fx (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req_fx),
        .out_ready  (rdy_fx),
        .out_valid  (vld_fx),
        .out_idx    (idx_fx),
        .out_onehot (oh_fx),
        .pend_cnt   (cnt_fx)
    );

    prio_encoder_q #(.N(N), .RR_MODE(1)) dut_rr (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req_rr),
        .out_ready  (rdy_rr),
        .out_valid  (vld_rr),
        .out_idx    (idx_rr),
        .out_onehot (oh_rr),
        .pend_cnt   (cnt_rr)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
            $display("chk %s ok value=%0h", tag, obs);
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [W-1:0] exp_idx;

        // reset, then idle
        step();
        step();
        chk("rst_valid", 64'(vld_fx), 64'd0);
        chk("rst_cnt", 64'(cnt_fx), 64'd0);
        chk("rst_idx", 64'(idx_fx), 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_valid", 64'(vld_fx), 64'd0);
            chk("idle_onehot", 64'(oh_fx), 64'd0);
            chk("idle_cnt", 64'(cnt_fx), 64'd0);
        end

        // fixed priority: three simultaneous requests serialised 7,5,1
        rdy_fx = 1'b1;
        req_fx = 8'b1010_0010;
        step();
        req_fx = '0;
        chk("fx_cnt3", 64'(cnt_fx), 64'd3);
        chk("fx_lat_valid", 64'(vld_fx), 64'd0);
        step();
        chk("fx_valid7", 64'(vld_fx), 64'd1);
        chk("fx_idx7", 64'(idx_fx), 64'd7);
        chk("fx_oh7", 64'(oh_fx), 64'h80);
        chk("fx_cnt2", 64'(cnt_fx), 64'd2);
        step();
        chk("fx_idx5", 64'(idx_fx), 64'd5);
        chk("fx_oh5", 64'(oh_fx), 64'h20);
        chk("fx_cnt1", 64'(cnt_fx), 64'd1);
        step();
        chk("fx_idx1", 64'(idx_fx), 64'd1);
        chk("fx_cnt0", 64'(cnt_fx), 64'd0);
        step();
        chk("fx_drop_valid", 64'(vld_fx), 64'd0);
        chk("fx_drop_onehot", 64'(oh_fx), 64'd0);
        chk("fx_idx_hold", 64'(idx_fx), 64'd1);

        // backpressure
        rdy_fx = 1'b0;
        req_fx = 8'h81;
        step();
        req_fx = '0;
        chk("bp_cnt2", 64'(cnt_fx), 64'd2);
        step();
        chk("bp_valid", 64'(vld_fx), 64'd1);
        chk("bp_idx7", 64'(idx_fx), 64'd7);
        chk("bp_cnt1", 64'(cnt_fx), 64'd1);
        req_fx = 8'h80;
        step();
        req_fx = '0;
        chk("bp_hold_idx", 64'(idx_fx), 64'd7);
        chk("bp_hold_valid", 64'(vld_fx), 64'd1);
        chk("bp_recnt2", 64'(cnt_fx), 64'd2);
        step();
        chk("bp_still_idx", 64'(idx_fx), 64'd7);
        chk("bp_still_cnt", 64'(cnt_fx), 64'd2);
        rdy_fx = 1'b1;
        step();
        chk("bp_rel_idx7", 64'(idx_fx), 64'd7);
        chk("bp_rel_cnt1", 64'(cnt_fx), 64'd1);
        step();
        chk("bp_rel_idx0", 64'(idx_fx), 64'd0);
        chk("bp_rel_oh0", 64'(oh_fx), 64'h01);
        chk("bp_rel_cnt0", 64'(cnt_fx), 64'd0);
        step();
        chk("bp_rel_valid0", 64'(vld_fx), 64'd0);

        // set wins over a same-cycle clear
        req_fx = 8'h08;
        step();
        chk("sw_cnt1", 64'(cnt_fx), 64'd1);
        step();
        req_fx = '0;
        chk("sw_idx3", 64'(idx_fx), 64'd3);
        chk("sw_kept_cnt", 64'(cnt_fx), 64'd1);
        step();
        chk("sw_again_valid", 64'(vld_fx), 64'd1);
        chk("sw_again_idx3", 64'(idx_fx), 64'd3);
        chk("sw_cnt0", 64'(cnt_fx), 64'd0);
        step();
        chk("sw_done_valid", 64'(vld_fx), 64'd0);

        // round robin with all lines requesting continuously
        rdy_rr = 1'b1;
        req_rr = 8'hFF;
        step();
        chk("rr_cnt8", 64'(cnt_rr), 64'd8);
        for (int i = 0; i < 9; i++) begin
            step();
            exp_idx = 3'(7 - i);
            chk("rr_idx", 64'(idx_rr), 64'(exp_idx));
            chk("rr_oh", 64'(oh_rr), 64'(8'h01 << exp_idx));
        end

        // reset mid-operation, with a request in the reset cycle
        rdy_rr = 1'b0;
        req_rr = 8'h0F;
        step();
        chk("mid_valid", 64'(vld_rr), 64'd1);
        rst = 1'b1;
        req_rr = 8'h02;
        step();
        rst = 1'b0;
        req_rr = '0;
        rdy_rr = 1'b1;
        chk("mid_rst_valid", 64'(vld_rr), 64'd0);
        chk("mid_rst_idx", 64'(idx_rr), 64'd0);
        chk("mid_rst_oh", 64'(oh_rr), 64'd0);
        chk("mid_rst_cnt", 64'(cnt_rr), 64'd0);
        step();
        chk("mid_post_cnt", 64'(cnt_rr), 64'd0);
        step();
        chk("mid_post_valid", 64'(vld_rr), 64'd0);
        req_rr = 8'h81;
        step();
        req_rr = '0;
        step();
        chk("mid_ptr_idx7", 64'(idx_rr), 64'd7);
        step();
        chk("mid_next_idx0", 64'(idx_rr), 64'd0);
        step();
        chk("mid_end_valid", 64'(vld_rr), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
